// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store physical-memory controller.
//   SZ_*  : request access size
//   ERR_* : response error code
//   state_t : controller FSM state
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for one access.
//   size, off   : access size and byte offset within the word
//   uns         : zero-extend loads (else sign-extend)
//   wdata       : right-aligned store data
//   mem_rdata   : full word returned by memory
//   wstrb       : byte strobes for a store
//   wdata_rep   : store data replicated across lanes
//   load_ext    : shifted and extended load result
//   misaligned  : size/offset combination is not legal
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_ext,
  output logic        misaligned
);
  logic [3:0][7:0] rep;
  logic [31:0]     sh;

  // Byte repeats lane 0 everywhere, half repeats the low halfword pair.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign rep[i] = (size == SZ_B) ? wdata[7:0] :
                    (size == SZ_H) ? wdata[8*(i%2) +: 8] :
                                     wdata[8*i +: 8];
  end
  assign wdata_rep = rep;

  assign misaligned = (size == 2'b11) ||
                      ((size == SZ_H) && off[0]) ||
                      ((size == SZ_W) && (off != 2'b00));

  always_comb begin
    wstrb = 4'b0000;
    case (size)
      SZ_B:    wstrb = 4'b0001 << off;
      SZ_H:    wstrb = 4'b0011 << off;
      SZ_W:    wstrb = 4'b1111;
      default: wstrb = 4'b0000;
    endcase
  end

  assign sh = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = mem_rdata;
    case (size)
      SZ_B:    load_ext = uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_ext = uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end
endmodule

// File: rtl/lsu_pmem_ctrl.sv
// Sequential load/store controller between the memory stage and a
// physical-memory port. One transaction at a time:
//   req_*  : valid/ready request from the core (accepted only in IDLE)
//   resp_* : valid/ready response (load data / error code)
//   mem_*  : memory request held until mem_ack or timeout
// Misaligned or illegal-size requests skip memory and answer ERR_MISALIGN.
module lsu_pmem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);
  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic              cap_we, cap_uns;
  logic [ADDR_W-1:0] cap_addr;
  logic [1:0]        cap_size;
  logic [31:0]       cap_wdata;
  logic [31:0]       rdata_q;
  logic [1:0]        err_q;

  logic        idle, busy, tmo;
  logic [1:0]  al_size, al_off;
  logic [3:0]  wstrb;
  logic [31:0] wdata_rep, load_ext;
  logic        misaligned;

  assign idle = (state == IDLE);
  assign busy = (state == BUSY);
  assign tmo  = (cnt == CNT_W'(TIMEOUT - 1));

  // In IDLE the aligner checks the incoming request; afterwards it works
  // from the captured request, so the memory outputs stay stable in BUSY.
  assign al_size = idle ? req_size      : cap_size;
  assign al_off  = idle ? req_addr[1:0] : cap_addr[1:0];

  lsu_lane_align u_align (
    .size       (al_size),
    .off        (al_off),
    .uns        (cap_uns),
    .wdata      (cap_wdata),
    .mem_rdata  (mem_rdata),
    .wstrb      (wstrb),
    .wdata_rep  (wdata_rep),
    .load_ext   (load_ext),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = misaligned ? RESP : BUSY;
      BUSY: if (mem_ack || tmo) state_nxt = RESP;
      RESP: if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_uns   <= 1'b0;
      cap_addr  <= '0;
      cap_size  <= 2'b00;
      cap_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= ERR_OK;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          cap_we    <= req_we;
          cap_uns   <= req_unsigned;
          cap_addr  <= req_addr;
          cap_size  <= req_size;
          cap_wdata <= req_wdata;
          cnt       <= '0;
          if (misaligned) begin
            rdata_q <= '0;
            err_q   <= ERR_MISALIGN;
          end
        end
        BUSY: begin
          // Ack takes priority over a timeout in the same cycle.
          if (mem_ack) begin
            rdata_q <= cap_we ? 32'b0 : load_ext;
            err_q   <= ERR_OK;
          end else if (tmo) begin
            rdata_q <= '0;
            err_q   <= ERR_TIMEOUT;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = idle;
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign mem_req   = busy;
  assign mem_we    = busy & cap_we;
  assign mem_addr  = busy ? {cap_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = busy ? wdata_rep : '0;
  assign mem_wstrb = (busy && cap_we) ? wstrb : 4'b0000;
endmodule

// File: tb/tb_lsu_pmem_ctrl.sv
// Directed scoreboard bench for lsu_pmem_ctrl (TIMEOUT = 4).
module tb_lsu_pmem_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 0, req_we = 0, req_unsigned = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [1:0]  req_size = 0;
  logic        resp_ready = 0, mem_ack = 0;
  logic [31:0] mem_rdata = 0;
  logic        req_ready, resp_valid, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [1:0]  resp_err;
  logic [3:0]  mem_wstrb;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;
  exp_t sb[$];

  int tests = 0;
  int fails = 0;

  lsu_pmem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present one request for one cycle; it is accepted at the next edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata);
    req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    check("req_ready_on_send", {31'b0, req_ready}, 1);
    tick();
    req_valid = 1'b0;
  endtask

  // Acknowledge the current BUSY cycle with the given read word.
  task automatic ack(input logic [31:0] rd);
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
  endtask

  // Wait (bounded) for a response, compare with scoreboard head, handshake.
  task automatic drain(input string tag);
    int n = 0;
    exp_t e;
    while (!resp_valid && n < 20) begin tick(); n++; end
    check({tag, "_resp_valid"}, {31'b0, resp_valid}, 1);
    check({tag, "_sb_size"}, sb.size(), 1);
    if (resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_err"}, {30'b0, resp_err}, {30'b0, e.err});
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "_resp_dropped"}, {31'b0, resp_valid}, 0);
    check({tag, "_req_ready_back"}, {31'b0, req_ready}, 1);
  endtask

  initial begin
    int n;
    // Reset state
    #12;
    check("rst_req_ready",  {31'b0, req_ready}, 1);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err",   {30'b0, resp_err}, 0);
    check("rst_mem_req",    {31'b0, mem_req}, 0);
    check("rst_mem_we",     {31'b0, mem_we}, 0);
    check("rst_mem_addr",   mem_addr, 0);
    check("rst_mem_wdata",  mem_wdata, 0);
    check("rst_mem_wstrb",  {28'b0, mem_wstrb}, 0);
    rst = 1'b0;
    tick();

    // Signed byte load, same-cycle ack, 2-cycle latency
    sb.push_back('{32'hFFFF_FF80, ERR_OK});
    send(0, 32'h8000_0003, SZ_B, 0, 0);
    check("lb_mem_req",   {31'b0, mem_req}, 1);
    check("lb_mem_addr",  mem_addr, 32'h8000_0000);
    check("lb_mem_wstrb", {28'b0, mem_wstrb}, 0);
    check("lb_mem_we",    {31'b0, mem_we}, 0);
    ack(32'h80FF_0000);
    check("lb_latency2", {31'b0, resp_valid}, 1);
    drain("lb");

    // Unsigned and signed half loads at offset 2
    sb.push_back('{32'h0000_8001, ERR_OK});
    send(0, 32'h1000_0002, SZ_H, 1, 0);
    ack(32'h8001_1234);
    drain("lhu");
    sb.push_back('{32'hFFFF_8001, ERR_OK});
    send(0, 32'h1000_0002, SZ_H, 0, 0);
    ack(32'h8001_1234);
    drain("lh");

    // Byte store at offset 1
    sb.push_back('{32'h0, ERR_OK});
    send(1, 32'h2000_0001, SZ_B, 0, 32'h0000_00AB);
    check("sb_mem_we",    {31'b0, mem_we}, 1);
    check("sb_mem_wstrb", {28'b0, mem_wstrb}, 4'b0010);
    check("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    check("sb_mem_addr",  mem_addr, 32'h2000_0000);
    ack(32'hDEAD_BEEF);
    drain("sb");

    // Half store at offset 2, word store
    sb.push_back('{32'h0, ERR_OK});
    send(1, 32'h2000_0006, SZ_H, 0, 32'h5555_BEEF);
    check("sh_mem_wstrb", {28'b0, mem_wstrb}, 4'b1100);
    check("sh_mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    check("sh_mem_addr",  mem_addr, 32'h2000_0004);
    ack(0);
    drain("sh");
    sb.push_back('{32'h0, ERR_OK});
    send(1, 32'h2000_0008, SZ_W, 0, 32'h1234_5678);
    check("sw_mem_wstrb", {28'b0, mem_wstrb}, 4'b1111);
    check("sw_mem_wdata", mem_wdata, 32'h1234_5678);
    ack(0);
    drain("sw");

    // Misaligned word, illegal size, odd half: 1-cycle error, no memory access
    sb.push_back('{32'h0, ERR_MISALIGN});
    send(0, 32'h3000_0002, SZ_W, 0, 0);
    check("mis_w_mem_req", {31'b0, mem_req}, 0);
    check("mis_w_latency1", {31'b0, resp_valid}, 1);
    drain("mis_w");
    sb.push_back('{32'h0, ERR_MISALIGN});
    send(0, 32'h3000_0000, 2'b11, 0, 0);
    check("mis_sz_mem_req", {31'b0, mem_req}, 0);
    drain("mis_sz");
    sb.push_back('{32'h0, ERR_MISALIGN});
    send(1, 32'h3000_0001, SZ_H, 0, 32'hFFFF);
    check("mis_h_mem_req", {31'b0, mem_req}, 0);
    drain("mis_h");

    // Timeout with no ack: exactly 4 BUSY cycles
    sb.push_back('{32'h0, ERR_TIMEOUT});
    send(0, 32'h4000_0000, SZ_W, 0, 0);
    n = 0;
    while (mem_req && n < 10) begin n++; tick(); end
    check("tmo_busy_cycles", n, 4);
    drain("tmo");

    // Ack on the 4th BUSY cycle beats the timeout
    sb.push_back('{32'h1234_5678, ERR_OK});
    send(0, 32'h4000_0004, SZ_W, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    check("late_ack_mem_req", {31'b0, mem_req}, 1);
    ack(32'h1234_5678);
    drain("late_ack");

    // Backpressure: response held stable, no new request accepted
    sb.push_back('{32'h0000_00AB, ERR_OK});
    send(0, 32'h5000_0000, SZ_B, 1, 0);
    ack(32'h0000_00AB);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", {31'b0, resp_valid}, 1);
      check("bp_resp_rdata", resp_rdata, 32'h0000_00AB);
      check("bp_req_ready",  {31'b0, req_ready}, 0);
      tick();
    end
    req_valid = 1'b0;
    drain("bp");

    // Reset mid-BUSY: immediate drop, no response
    send(0, 32'h6000_0000, SZ_W, 0, 0);
    check("rb_mem_req_before", {31'b0, mem_req}, 1);
    #1 rst = 1'b1;
    #1;
    check("rb_mem_req",    {31'b0, mem_req}, 0);
    check("rb_req_ready",  {31'b0, req_ready}, 1);
    check("rb_resp_valid", {31'b0, resp_valid}, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (resp_valid || mem_req) n++;
    end
    check("rb_no_response", n, 0);

    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_pmem_ctrl.md
Name: lsu_pmem_ctrl

Overview:
- Sequential load/store controller that sits between the core's memory stage and a physical-memory port.
- Accepts one load or store per transaction through a valid/ready handshake.
- Performs byte-lane alignment, store-strobe generation, load sign/zero extension and misalignment checking.
- Holds the memory request until it is acknowledged, or until a timeout expires, then returns a response through a valid/ready handshake.

Parameters:
- ADDR_W, 32, width of request and memory addresses.
- TIMEOUT, 255, maximum number of BUSY cycles without mem_ack before an error is reported. Must be ≥1.
- CNT_W, $clog2(TIMEOUT+1), width of the wait counter. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  transaction request.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load data; 0 for stores and on error.
- resp_err  out  2  00 ok, 01 misaligned/illegal size, 10 timeout.
- mem_req  out  1  memory access request.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word address: {req_addr[ADDR_W-1:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte strobes; 0000 for loads.
- mem_ack  in  1  memory completes the access this cycle. mem_rdata is valid with it.
- mem_rdata  in  32  full aligned word read.

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (async, immediate): state IDLE, counter 0, all captured registers 0.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=00, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - Reset asserted in BUSY or RESP drops mem_req/resp_valid in the same cycle; the transaction is lost.
- IDLE: req_ready=1. On req_valid, capture we/addr/size/unsigned/wdata.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]≠0, or size=11): go to RESP with err=01. No memory access is made.
  - Aligned request: go to BUSY and clear the counter.
- BUSY: mem_req=1; mem_we, mem_addr, mem_wdata and mem_wstrb are held stable from the captured values.
  - mem_ack=1: register the extended load data (0 for a store), err=00, go to RESP.
  - No ack and counter==TIMEOUT-1: err=10, rdata=0, go to RESP.
  - Otherwise increment the counter.
  - mem_ack in the same cycle as the timeout condition: the ack wins.
- RESP: resp_valid=1 with resp_rdata/resp_err stable until resp_ready. On resp_valid&&resp_ready go to IDLE.
  - No request is accepted in the handshake cycle; req_ready is combinational on state.
- Latency, accept to resp_valid:
  - 2 cycles with same-cycle ack (accept in c0, BUSY in c1 with ack, resp_valid in c2).
  - 1 cycle for a misalignment error.
- Store strobes (off = addr[1:0]):
  - Byte: 0001<<off.
  - Half: 0011<<off.
  - Word: 1111.
- Store data:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load: shifted = mem_rdata >> (8*off). Byte takes shifted[7:0] and half takes shifted[15:0], each extended to 32 bits per req_unsigned. Word is passed unchanged.
- The counter saturates and never wraps; it is cleared on entry to BUSY.

Decomposition:
- Package lsu_pkg:
  - Size encodings: SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10.
  - Error codes: ERR_OK=2'b00, ERR_MISALIGN=2'b01, ERR_TIMEOUT=2'b10.
  - State enum {IDLE, BUSY, RESP}.
- Sub-module lsu_lane_align: purely combinational.
  - Inputs: size, off, unsigned, wdata, mem_rdata.
  - Outputs: wstrb, wdata_rep, load_ext, misaligned.
  - The FSM, counter and registers stay in lsu_pmem_ctrl.

Test Plan:
- Signed byte load: lb at addr 0x8000_0003 with mem_rdata=0x80FF_0000 and ack in first BUSY cycle -> mem_addr=0x8000_0000, mem_wstrb=0000, resp_rdata=0xFFFF_FF80, err=00, resp_valid 2 cycles after accept.
- Unsigned half load: lhu at 0x...2, mem_rdata=0x8001_1234 -> resp_rdata=0x0000_8001.
- Byte store: sb at 0x...1 with wdata=0x0000_00AB -> mem_we=1, mem_wstrb=0010, mem_wdata=0xABAB_ABAB, resp_rdata=0.
- Misaligned word: lw at 0x...2 -> mem_req never asserted, resp_err=01 one cycle after accept. size=11 gives the same result.
- Timeout: TIMEOUT=4 with mem_ack held 0 -> mem_req high exactly 4 cycles, then resp_err=10. A second run with ack arriving on the 4th BUSY cycle -> err=00.
- Backpressure and reset: resp_ready=0 for 5 cycles -> resp_valid/rdata stable and req_ready=0 throughout. Asserting rst mid-BUSY -> mem_req=0 and req_ready=1 immediately, with no response produced.
